scan_chain_driver: RTL and testbench

SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

---
 rtl/scan_chain_driver_pkg.sv | 27 ++
 rtl/scan_chain_driver_counter.sv | 27 ++
 rtl/scan_chain_driver.sv | 130 +++++++++++++
 tb/tb_scan_chain_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_driver_pkg.sv
// Shared processor package: scan driver FSM states, scan bit order and control FSM states.
package scan_chain_driver_pkg;

    localparam int unsigned ByteBits = 8;

    // First bit presented to the chain is bit 0 of each host byte.
    localparam bit ScanLsbFirst = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StUnload,
        StFinish
    } scan_state_e;

    typedef enum logic [1:0] {
        CtrlRun,
        CtrlHold,
        CtrlScan
    } ctrl_state_e;

    function automatic int unsigned last_byte_bits(int unsigned chain_len, int unsigned nbytes);
        return chain_len - ByteBits * (nbytes - 1);
    endfunction

endpackage

// File: rtl/scan_chain_driver_counter.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module scan_bit_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/scan_chain_driver.sv
// Byte-wide host interface that shifts a session of bytes through an external scan chain
// while holding the processor, capturing the bits that fall out of the chain.
module scan_chain_driver
    import scan_chain_driver_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 4,
    // Derived from CHAIN_LEN; not meant to be overridden.
    parameter int unsigned NBYTES    = (CHAIN_LEN + 7) / 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       cpu_hold,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out
);

    localparam int unsigned LastBits = last_byte_bits(CHAIN_LEN, NBYTES);
    localparam int unsigned ByteCntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TxBit    = ScanLsbFirst ? 0 : ByteBits - 1;

    localparam logic [2:0]          FullLoad  = 3'(ByteBits - 1);
    localparam logic [2:0]          LastLoad  = 3'(LastBits - 1);
    localparam logic [2:0]          LastShift = 3'(ByteBits - LastBits);
    localparam logic [ByteCntW-1:0] ByteLoad  = ByteCntW'(NBYTES - 1);

    scan_state_e state_q, state_d;
    logic [7:0]  shreg_q;
    logic [7:0]  out_data_q;
    logic        in_ready_q, out_valid_q, busy_q, done_q, scan_enable_q;

    logic        bit_zero, byte_zero;
    logic        in_hs, out_hs;
    logic [7:0]  shift_next, aligned;
    logic [2:0]  out_shift;

    assign in_hs  = (state_q == StLoad) && in_valid;
    assign out_hs = (state_q == StUnload) && out_ready;

    // Bit count of the current byte: loaded with (bits - 1), SHIFT ends on zero.
    scan_bit_counter #(
        .Width (3)
    ) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (in_hs),
        .load_value (byte_zero ? LastLoad : FullLoad),
        .dec        (state_q == StShift),
        .zero       (bit_zero)
    );

    // Bytes remaining after the current one; zero marks the last byte of the session.
    scan_bit_counter #(
        .Width (ByteCntW)
    ) u_byte_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       ((state_q == StIdle) && start),
        .load_value (ByteLoad),
        .dec        (out_hs),
        .zero       (byte_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StLoad;
            StLoad:   if (in_valid) state_d = StShift;
            StShift:  if (bit_zero) state_d = StUnload;
            StUnload: if (out_ready) state_d = byte_zero ? StFinish : StLoad;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // A short last byte leaves its captured bits at the top of the register.
    always_comb begin
        shift_next = ScanLsbFirst ? {scan_out, shreg_q[7:1]} : {shreg_q[6:0], scan_out};
        out_shift  = byte_zero ? LastShift : 3'd0;
        aligned    = ScanLsbFirst ? (shift_next >> out_shift)
                                  : (shift_next & (8'hFF >> out_shift));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            shreg_q       <= '0;
            out_data_q    <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            scan_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= (state_d == StLoad);
            out_valid_q   <= (state_d == StUnload);
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StFinish);
            scan_enable_q <= (state_d == StShift);
            if (in_hs) begin
                shreg_q <= in_data;
            end else if (state_q == StShift) begin
                shreg_q <= shift_next;
            end
            if ((state_q == StShift) && bit_zero) begin
                out_data_q <= aligned;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign cpu_hold    = busy_q;
    assign done        = done_q;
    assign scan_enable = scan_enable_q;
    assign scan_in     = scan_enable_q & shreg_q[TxBit];

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench: a 4-flop and a 12-flop chain model, each behind its own driver instance.
module tb_scan_chain_driver;

    logic clk, rst;

    logic       start4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic       busy4, done4, cpu_hold4, scan_enable4, scan_in4, scan_out4;
    logic [7:0] in_data4, out_data4;

    logic       start12, in_valid12, in_ready12, out_valid12, out_ready12;
    logic       busy12, done12, cpu_hold12, scan_enable12, scan_in12, scan_out12;
    logic [7:0] in_data12, out_data12;

    logic [3:0]  chain4, pval4;
    logic [11:0] chain12, pval12;
    logic        preload4, preload12;

    int checks = 0;
    int errors = 0;
    int ndone4 = 0;
    int ndone12 = 0;

    scan_chain_driver #(.CHAIN_LEN(4)) dut4 (
        .clk (clk), .rst (rst), .start (start4),
        .in_data (in_data4), .in_valid (in_valid4), .in_ready (in_ready4),
        .out_data (out_data4), .out_valid (out_valid4), .out_ready (out_ready4),
        .busy (busy4), .done (done4), .cpu_hold (cpu_hold4),
        .scan_enable (scan_enable4), .scan_in (scan_in4), .scan_out (scan_out4)
    );

    scan_chain_driver #(.CHAIN_LEN(12)) dut12 (
        .clk (clk), .rst (rst), .start (start12),
        .in_data (in_data12), .in_valid (in_valid12), .in_ready (in_ready12),
        .out_data (out_data12), .out_valid (out_valid12), .out_ready (out_ready12),
        .busy (busy12), .done (done12), .cpu_hold (cpu_hold12),
        .scan_enable (scan_enable12), .scan_in (scan_in12), .scan_out (scan_out12)
    );

    // Chain models: scan_in enters at the top, scan_out is bit 0.
    always @(posedge clk) begin
        if (preload4) chain4 <= pval4;
        else if (scan_enable4) chain4 <= {scan_in4, chain4[3:1]};
        if (preload12) chain12 <= pval12;
        else if (scan_enable12) chain12 <= {scan_in12, chain12[11:1]};
    end
    assign scan_out4  = chain4[0];
    assign scan_out12 = chain12[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done4) ndone4++;
        if (done12) ndone12++;
    endtask

    // Runs dut4 from just after the start edge until done is visible (bounded).
    task automatic run4(input int cyc0, output int cyc, output logic [7:0] got,
                        output logic [3:0] si, output int nse);
        cyc = cyc0;
        got = 8'h00;
        si  = 4'h0;
        nse = 0;
        while (!done4 && cyc < 60) begin
            if (scan_enable4) begin
                if (nse < 4) si[nse] = scan_in4;
                nse++;
            end
            if (out_valid4) got = out_data4;
            tick();
            cyc++;
        end
        check("run4_reached_done", {31'd0, done4}, 32'd1);
    endtask

    int          cyc, nse, d0, nout;
    logic [7:0]  got, held;
    logic [3:0]  si;
    logic        se_seen, hold_ok, stable;

    initial begin
        rst = 1'b1;
        start4 = 0; in_valid4 = 0; out_ready4 = 0; in_data4 = 0;
        start12 = 0; in_valid12 = 0; out_ready12 = 0; in_data12 = 0;
        preload4 = 0; pval4 = 0; preload12 = 0; pval12 = 0;
        tick();
        tick();
        check("reset_ctrl4", {in_ready4, out_valid4, busy4, done4, cpu_hold4, scan_enable4,
                              scan_in4}, 32'd0);
        check("reset_out4", out_data4, 32'h00);
        check("reset_ctrl12", {in_ready12, out_valid12, busy12, done12, cpu_hold12,
                               scan_enable12, scan_in12}, 32'd0);
        rst = 1'b0;

        // Basic session: chain 1010, in 0x0C -> out 0x0A, chain 1100.
        preload4 = 1; pval4 = 4'b1010;
        tick();
        preload4 = 0;
        in_valid4 = 1; out_ready4 = 1; in_data4 = 8'h0C; start4 = 1;
        tick();
        start4 = 0;
        check("load_after_start", {busy4, cpu_hold4, in_ready4, scan_enable4}, 32'b1110);
        run4(1, cyc, got, si, nse);
        // Start cycle counted as 0; done cycle is NBYTES*2+CHAIN_LEN+1 = 7 (8 cycles inclusive).
        check("latency4", cyc, 32'd7);
        check("out_0x0A", got, 32'h0A);
        check("scan_in_order", si, 32'b1100);
        check("shift_cycles", nse, 32'd4);
        check("chain_after_A", chain4, 32'b1100);
        tick();
        check("done_one_cycle", {done4, busy4}, 32'd0);
        check("done_count_A", ndone4, 32'd1);

        // Start pulsed during SHIFT is ignored.
        d0 = ndone4;
        in_data4 = 8'h05; start4 = 1;
        tick();
        start4 = 0;
        tick();
        check("in_shift", scan_enable4, 32'd1);
        start4 = 1;
        tick();
        start4 = 0;
        run4(3, cyc, got, si, nse);
        check("out_B", got, 32'h0C);
        for (int i = 0; i < 8; i++) tick();
        check("single_done_B", ndone4 - d0, 32'd1);
        check("idle_after_B", {busy4, in_ready4}, 32'd0);
        check("chain_after_B", chain4, 32'b0101);

        // Host stall in LOAD: chain must not move.
        in_valid4 = 0; in_data4 = 8'h00; start4 = 1;
        tick();
        start4 = 0;
        se_seen = 0; hold_ok = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            se_seen = se_seen | scan_enable4;
            hold_ok = hold_ok & busy4 & cpu_hold4 & in_ready4;
        end
        check("stall_no_se", se_seen, 32'd0);
        check("stall_hold", hold_ok, 32'd1);
        check("stall_chain", chain4, 32'b0101);
        in_valid4 = 1;
        run4(6, cyc, got, si, nse);
        check("out_C", got, 32'h05);
        check("chain_after_C", chain4, 32'b0000);
        tick();

        // Loopback through the 4-flop chain.
        in_data4 = 8'h09; start4 = 1;
        tick();
        start4 = 0;
        run4(1, cyc, got, si, nse);
        check("loop_first", got, 32'h00);
        check("latency_loop", cyc, 32'd7);
        tick();
        in_data4 = 8'h00; start4 = 1;
        tick();
        start4 = 0;
        run4(1, cyc, got, si, nse);
        check("loop_second", got, 32'h09);
        tick();

        // 12-flop chain, two bytes, out_ready stall on first out byte.
        d0 = ndone12;
        preload12 = 1; pval12 = 12'h5C3;
        tick();
        preload12 = 0;
        in_valid12 = 1; in_data12 = 8'hA5; out_ready12 = 0; start12 = 1;
        tick();
        start12 = 0;
        tick();
        in_data12 = 8'h03;
        cyc = 0;
        while (!out_valid12 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("out12_first_valid", out_valid12, 32'd1);
        held = out_data12;
        check("out12_byte0", held, 32'hC3);
        se_seen = 0; stable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            se_seen = se_seen | scan_enable12;
            stable = stable & out_valid12 & (out_data12 == held);
        end
        check("stall12_no_se", se_seen, 32'd0);
        check("stall12_stable", stable, 32'd1);
        out_ready12 = 1;
        tick();
        nout = 1;
        got = 8'h00;
        cyc = 0;
        while (!done12 && cyc < 40) begin
            if (out_valid12) begin
                nout++;
                got = out_data12;
            end
            tick();
            cyc++;
        end
        check("done12_reached", done12, 32'd1);
        check("out12_count", nout, 32'd2);
        check("out12_byte1", got, 32'h05);
        check("chain12_after", chain12, 32'h3A5);
        for (int i = 0; i < 4; i++) tick();
        check("done12_once", ndone12 - d0, 32'd1);

        // Reset on the 2nd SHIFT cycle aborts without done.
        d0 = ndone4;
        in_valid4 = 1; out_ready4 = 1; in_data4 = 8'hFF; start4 = 1;
        tick();
        start4 = 0;
        tick();
        tick();
        check("second_shift", scan_enable4, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ctrl", {in_ready4, out_valid4, busy4, done4, cpu_hold4, scan_enable4,
                             scan_in4}, 32'd0);
        check("abort_out", out_data4, 32'h00);
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_done", ndone4 - d0, 32'd0);
        check("abort_stays_idle", busy4, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
